alu_pipe_cc: RTL

//  Parametrised two-stage pipelined integer ALU (ADD/SUB/AND/XOR) for the execute stage.
//  Two's-complement signed operands; per-result signed-overflow flag.

---
 rtl/alu_pipe_cc.sv | 131 +++++++++++++
 1 files changed

// File: rtl/alu_pipe_cc.sv
// Two-stage pipelined integer ALU (ADD/SUB/AND/XOR) with valid/ready handshakes
// and an architectural ZF/SF/OF condition-code register updated on retirement.
module alu_pipe_cc #(
  parameter int unsigned WIDTH    = 64,
  parameter logic [2:0]  CC_RESET = 3'b100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_of,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  logic             s1_valid_q;
  op_e              s1_op_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic             s1_set_cc_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_y_q;
  logic             s2_of_q;
  logic             s2_set_cc_q;

  logic [2:0]       cc_q;

  logic             s2_adv;
  logic             accept;
  logic             retire;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] y_d;
  logic             of_d;

  assign s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~flush & (~s1_valid_q | s2_adv);
  assign accept   = in_valid & in_ready;
  // A flush cycle never counts as a retirement, even with out_ready high.
  assign retire   = s2_valid_q & out_ready & ~flush;

  // SUB reuses the adder as a + ~b + 1; overflow test then uses the inverted b sign.
  always_comb begin
    is_sub = (s1_op_q == OP_SUB);
    b_eff  = is_sub ? ~s1_b_q : s1_b_q;
    sum    = s1_a_q + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
    y_d    = sum;
    of_d   = 1'b0;
    case (s1_op_q)
      OP_ADD, OP_SUB: begin
        y_d  = sum;
        of_d = (s1_a_q[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      OP_AND:  y_d = s1_a_q & s1_b_q;
      OP_XOR:  y_d = s1_a_q ^ s1_b_q;
      default: y_d = sum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_set_cc_q <= 1'b0;
    end else if (flush) begin
      s1_valid_q  <= 1'b0;
    end else if (accept) begin
      s1_valid_q  <= 1'b1;
      s1_op_q     <= op_e'(in_op);
      s1_a_q      <= in_a;
      s1_b_q      <= in_b;
      s1_set_cc_q <= in_set_cc;
    end else if (s2_adv) begin
      s1_valid_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_y_q      <= '0;
      s2_of_q     <= 1'b0;
      s2_set_cc_q <= 1'b0;
    end else if (flush) begin
      s2_valid_q  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q  <= 1'b1;
      s2_y_q      <= y_d;
      s2_of_q     <= of_d;
      s2_set_cc_q <= s1_set_cc_q;
    end else if (retire) begin
      s2_valid_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= CC_RESET;
    end else if (retire && s2_set_cc_q) begin
      cc_q <= {(s2_y_q == '0), s2_y_q[WIDTH-1], s2_of_q};
    end
  end

  assign out_valid = s2_valid_q;
  assign out_y     = s2_y_q;
  assign out_of    = s2_of_q;
  assign cc_zf     = cc_q[2];
  assign cc_sf     = cc_q[1];
  assign cc_of     = cc_q[0];

endmodule
